nn_in_loader: RTL

NN_IN_LOADER -- requirements
Module: nn_in_loader

---
 rtl/nn_pkg.sv | 23 ++
 rtl/nn_sym_counter.sv | 24 ++
 rtl/nn_in_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the NN input loader.
package nn_pkg;

  localparam int N_PIX  = 144;
  localparam int N_WGT  = 9;
  localparam int N_FLT  = 4;
  localparam int PIX_W  = 2;
  localparam int N_COEF = N_WGT * N_FLT;
  localparam int IMG_W  = N_PIX * PIX_W;
  localparam int FLT_W  = N_WGT * PIX_W;

  typedef enum logic [1:0] {
    LOAD_PIX = 2'd0,
    LOAD_FLT = 2'd1,
    HOLD     = 2'd2
  } state_t;

  // Index of the final symbol of the phase the loader is currently in.
  function automatic logic [7:0] last_index(input state_t st);
    return (st == LOAD_PIX) ? 8'(N_PIX - 1) : 8'(N_COEF - 1);
  endfunction

endpackage

// File: rtl/nn_sym_counter.sv
// Symbol counter for the input loader, with terminal-count compare.
module nn_sym_counter
  import nn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic [7:0] last_idx,
  output logic [7:0] cnt,
  output logic       at_last
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 8'd0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign at_last = (cnt == last_idx);

endmodule

// File: rtl/nn_in_loader.sv
// Serial-to-parallel loader: 144 pixels then 36 filter weights, held until ack.
// Optional macro NN_LOAD_FILTER_ONCE_EN: load filters only in the first frame after reset.
module nn_in_loader
  import nn_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  input  logic [1:0]   s_data,
  output logic         s_ready,
  output logic [287:0] img,
  output logic [17:0]  filter1,
  output logic [17:0]  filter2,
  output logic [17:0]  filter3,
  output logic [17:0]  filter4,
  output logic         img_valid,
  input  logic         ack
);

  localparam int DATA_W = PIX_W;

  state_t                    state;
  logic [7:0]                cnt;
  logic                      at_last;
  logic                      accept;
  logic                      done;
  logic                      leave_hold;
  logic                      skip_flt;
  logic [8:0]                img_idx;
  logic [6:0]                flt_idx;
  logic [N_COEF*PIX_W-1:0]   flt;

  assign accept     = s_valid && s_ready;
  assign done       = accept && at_last;
  assign leave_hold = (state == HOLD) && ack;

  // Weight m of the flat filter vector sits at bits [2m+1:2m], which is
  // exactly filter(m/9+1) weight m%9 once the vector is split into 18-bit slices.
  assign img_idx = {cnt, 1'b0};
  assign flt_idx = {cnt[5:0], 1'b0};

  nn_sym_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept),
    .clr      (done || leave_hold),
    .last_idx (last_index(state)),
    .cnt      (cnt),
    .at_last  (at_last)
  );

`ifdef NN_LOAD_FILTER_ONCE_EN
  logic flt_loaded;
  assign skip_flt = flt_loaded;
`else
  assign skip_flt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_PIX;
      img       <= '0;
      flt       <= '0;
      img_valid <= 1'b0;
      s_ready   <= 1'b1;
`ifdef NN_LOAD_FILTER_ONCE_EN
      flt_loaded <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD_PIX: begin
          if (accept) begin
            img[img_idx +: DATA_W] <= s_data;
            if (at_last) begin
              if (skip_flt) begin
                state     <= HOLD;
                img_valid <= 1'b1;
                s_ready   <= 1'b0;
              end else begin
                state <= LOAD_FLT;
              end
            end
          end
        end
        LOAD_FLT: begin
          if (accept) begin
            flt[flt_idx +: DATA_W] <= s_data;
            if (at_last) begin
              state     <= HOLD;
              img_valid <= 1'b1;
              s_ready   <= 1'b0;
`ifdef NN_LOAD_FILTER_ONCE_EN
              flt_loaded <= 1'b1;
`endif
            end
          end
        end
        HOLD: begin
          if (ack) begin
            state     <= LOAD_PIX;
            img_valid <= 1'b0;
            s_ready   <= 1'b1;
          end
        end
        default: begin
          state     <= LOAD_PIX;
          img_valid <= 1'b0;
          s_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign filter1 = flt[1*FLT_W-1:0*FLT_W];
  assign filter2 = flt[2*FLT_W-1:1*FLT_W];
  assign filter3 = flt[3*FLT_W-1:2*FLT_W];
  assign filter4 = flt[4*FLT_W-1:3*FLT_W];

endmodule
